// File: rtl/updn_counter_pkg.sv
// rtl/updn_counter_pkg.sv - shared end-of-count mode definitions for the up/down counter
package updn_counter_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_WRAP    = 2'b00;
    localparam mode_t MODE_SAT     = 2'b01;
    localparam mode_t MODE_ONESHOT = 2'b10;

endpackage

// File: rtl/updn_next_calc.sv
// rtl/updn_next_calc.sv - combinational next-count, terminal and carry calculation
module updn_next_calc
    import updn_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] max,
    input  logic             up_dn,
    input  mode_t            mode,
    output logic [WIDTH-1:0] next_q,
    output logic             at_term,
    output logic             co_next
);

    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] max_ext;
    logic [WIDTH:0] inc;
    logic [WIDTH:0] dec;

    always_comb begin
        q_ext   = {1'b0, q};
        max_ext = {1'b0, max};
        inc     = q_ext + ONE;
        dec     = q_ext - ONE;
        // Up terminal is q >= max (q+1 > max); down terminal is the borrow out of q-1.
        at_term = up_dn ? dec[WIDTH] : (inc > max_ext);
        co_next = at_term;
        next_q  = q;
        if (!at_term) begin
            next_q = up_dn ? dec[WIDTH-1:0] : inc[WIDTH-1:0];
        end else if (mode != MODE_SAT && mode != MODE_ONESHOT) begin
            next_q = up_dn ? max : '0;
        end
    end

endmodule

// File: rtl/updn_counter_mod.sv
// rtl/updn_counter_mod.sv - parametrised up/down counter with runtime modulus and cascade
module updn_counter_mod
    import updn_counter_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             CLK,
    input  logic             MR,
    input  logic             Load,
    input  logic             EN,
    input  logic             CI,
    input  logic             Up_Dn,
    input  mode_t            Mode,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] Max,
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    output logic             TC,
    output logic             Done
);

    localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] load_q;
    logic             at_term;
    logic             co_next;
    logic             hold;

    updn_next_calc #(.WIDTH(WIDTH)) u_next (
        .q       (Q),
        .max     (Max),
        .up_dn   (Up_Dn),
        .mode    (Mode),
        .next_q  (next_q),
        .at_term (at_term),
        .co_next (co_next)
    );

    assign load_q = (D > Max) ? Max : D;
    assign hold   = EN | ~CI | Done;
    // Combinational so the next stage steps on the same edge this one wraps.
    assign TC     = CI & ~EN & Load & ~Done & at_term;

    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            Q    <= RST_Q;
            CO   <= 1'b0;
            Done <= 1'b0;
        end else if (!Load) begin
            Q    <= load_q;
            CO   <= 1'b0;
            Done <= 1'b0;
        end else if (hold) begin
            CO   <= 1'b0;
        end else begin
            Q  <= next_q;
            CO <= co_next;
            if (at_term && Mode == MODE_ONESHOT) begin
                Done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_updn_counter_mod.sv
// tb/tb_updn_counter_mod.sv - randomized model-checked bench for updn_counter_mod
module tb_updn_counter_mod;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         MR, Load, EN, CI, Up_Dn;
    logic [1:0]   Mode;
    logic [W-1:0] D, Max, Q;
    logic         CO, TC, Done;

    logic         c_load, c_en;
    logic [W-1:0] c_max0;
    logic [W-1:0] c0_q, c1_q;
    logic         c0_co, c1_co, c0_tc, c1_tc, c0_done, c1_done;

    int n_cmp = 0;
    int n_bad = 0;

    int m_q, m_co, m_done;
    int m_cas, m_cas_co;
    bit chk_en  = 1'b0;
    bit cas_chk = 1'b0;

    updn_counter_mod #(.WIDTH(W), .RESET_VAL(0)) dut (
        .CLK(CLK), .MR(MR), .Load(Load), .EN(EN), .CI(CI), .Up_Dn(Up_Dn), .Mode(Mode),
        .D(D), .Max(Max), .Q(Q), .CO(CO), .TC(TC), .Done(Done)
    );

    updn_counter_mod #(.WIDTH(W), .RESET_VAL(0)) c0 (
        .CLK(CLK), .MR(MR), .Load(c_load), .EN(c_en), .CI(1'b1), .Up_Dn(1'b0), .Mode(2'b00),
        .D('0), .Max(c_max0), .Q(c0_q), .CO(c0_co), .TC(c0_tc), .Done(c0_done)
    );

    updn_counter_mod #(.WIDTH(W), .RESET_VAL(0)) c1 (
        .CLK(CLK), .MR(MR), .Load(c_load), .EN(c_en), .CI(c0_tc), .Up_Dn(1'b0), .Mode(2'b00),
        .D('0), .Max(4'd15), .Q(c1_q), .CO(c1_co), .TC(c1_tc), .Done(c1_done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic from the counter's rules.
    always @(posedge CLK or posedge MR) begin
        if (MR) begin
            m_q = 0; m_co = 0; m_done = 0;
            m_cas = 0; m_cas_co = 0;
        end else begin
            if (!Load) begin
                m_q = (int'(D) < int'(Max)) ? int'(D) : int'(Max);
                m_co = 0; m_done = 0;
            end else if (EN || !CI || m_done != 0) begin
                m_co = 0;
            end else begin
                bit term;
                term = Up_Dn ? (m_q == 0) : (m_q >= int'(Max));
                m_co = term ? 1 : 0;
                if (!term) m_q = Up_Dn ? m_q - 1 : m_q + 1;
                else if (Mode == 2'b10) m_done = 1;
                else if (Mode != 2'b01) m_q = Up_Dn ? int'(Max) : 0;
            end
            if (!c_load) begin
                m_cas = 0; m_cas_co = 0;
            end else if (!c_en) begin
                m_cas_co = (m_cas == 255) ? 1 : 0;
                m_cas = (m_cas + 1) % 256;
            end else begin
                m_cas_co = 0;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("q", 32'(Q), m_q);
            check("co", 32'(CO), m_co);
            check("done", 32'(Done), m_done);
            check("tc", 32'(TC), (CI && !EN && Load && m_done == 0 &&
                                  (Up_Dn ? (m_q == 0) : (m_q >= int'(Max)))) ? 1 : 0);
        end
        if (cas_chk) begin
            check("cas_val", 32'({c1_q, c0_q}), m_cas);
            check("cas_co1", 32'(c1_co), m_cas_co);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic load(input logic [W-1:0] d);
        Load = 1'b0; D = d;
        tick();
        Load = 1'b1;
    endtask

    initial begin
        MR = 1'b1; Load = 1'b1; EN = 1'b1; CI = 1'b1; Up_Dn = 1'b0; Mode = 2'b00;
        D = '0; Max = 4'd9; c_load = 1'b1; c_en = 1'b1; c_max0 = 4'd15;
        #12;
        check("rst_q", 32'(Q), 0);
        check("rst_co", 32'(CO), 0);
        check("rst_done", 32'(Done), 0);
        tick();
        MR = 1'b0;
        chk_en = 1'b1;

        // Wrap up 0..9 then 0
        load(4'd0);
        EN = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("wrapup_q", 32'(Q), k % 10);
            check("wrapup_co", 32'(CO), (k == 10) ? 1 : 0);
            if (k == 9) check("wrapup_tc9", 32'(TC), 1);
        end

        // Mid-count asynchronous reset, observed before the next edge
        tick(); tick();
        MR = 1'b1;
        #1;
        check("mr_q", 32'(Q), 0);
        check("mr_co", 32'(CO), 0);
        check("mr_done", 32'(Done), 0);
        tick();
        MR = 1'b0;

        // Wrap down 2,1,0,9,8
        EN = 1'b1; Up_Dn = 1'b1;
        load(4'd2);
        EN = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("wrapdn_q", 32'(Q), (k == 0) ? 1 : (k == 1) ? 0 : (k == 2) ? 9 : 8);
            check("wrapdn_co", 32'(CO), (k == 2) ? 1 : 0);
        end

        // Saturate with load clamp
        EN = 1'b1; Up_Dn = 1'b0; Mode = 2'b01; Max = 4'd5;
        load(4'd12);
        check("sat_clamp", 32'(Q), 5);
        EN = 1'b0;
        tick(); check("sat_co1", 32'(CO), 1); check("sat_q1", 32'(Q), 5);
        tick(); check("sat_co2", 32'(CO), 1);
        EN = 1'b1;
        tick(); check("sat_hold_co", 32'(CO), 0);

        // One-shot
        Mode = 2'b10; Max = 4'd3;
        load(4'd0);
        EN = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("os_q", 32'(Q), (k < 3) ? k : 3);
            check("os_done", 32'(Done), (k >= 4) ? 1 : 0);
            check("os_co", 32'(CO), (k == 4) ? 1 : 0);
        end
        load(4'd1);
        check("os_reload_q", 32'(Q), 1);
        check("os_reload_done", 32'(Done), 0);

        // Max = 0: CO every step, Q stays 0
        Mode = 2'b00; Max = 4'd0;
        load(4'd7);
        tick();
        check("max0_q", 32'(Q), 0);
        check("max0_co", 32'(CO), 1);

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 2000; i++) begin
            Load  = ($urandom_range(15) != 0);
            EN    = ($urandom_range(7) == 0);
            CI    = ($urandom_range(7) != 0);
            if ($urandom_range(7) == 0) Up_Dn = ~Up_Dn;
            if ($urandom_range(31) == 0) Mode = 2'($urandom_range(3));
            if ($urandom_range(31) == 0) Max = 4'($urandom_range(15));
            D = 4'($urandom_range(15));
            MR = ($urandom_range(199) == 0);
            tick();
        end
        MR = 1'b0;
        EN = 1'b1;

        // Cascade: 8-bit composite through 0xFF -> 0x00
        c_load = 1'b0;
        tick();
        c_load = 1'b1; c_en = 1'b0;
        cas_chk = 1'b1;
        for (int i = 0; i < 260; i++) tick();
        cas_chk = 1'b0;
        for (int i = 0; i < 20 && c0_q != 4'd7; i++) tick();
        check("cas_find7", 32'(c0_q), 7);
        begin
            int s1b;
            s1b = int'(c1_q);
            c_max0 = 4'd3;
            tick();
            check("cas_lowmax_q0", 32'(c0_q), 0);
            check("cas_lowmax_q1", 32'(c1_q), (s1b + 1) % 16);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/updn_counter_mod.md
Name: updn_counter_mod

Overview:
Parametrised synchronous up/down counter with runtime modulus, selectable end-of-count mode and cascade support. It is the general-purpose successor to the fixed 4-bit up/down counter. Intended uses are timers, dividers and address generators, and multi-stage counters built by chaining CI/TC.

Parameters:
WIDTH, 4, counter width in bits (2..32).
RESET_VAL, 0, value loaded into Q on MR; must be <= 2**WIDTH-1.

Ports:
CLK  input  1  rising-edge clock.
MR  input  1  asynchronous active-high reset.
Load  input  1  active-low synchronous parallel load.
EN  input  1  active-low count enable.
CI  input  1  active-high cascade enable; tie 1 when unused.
Up_Dn  input  1  direction: 0 = up, 1 = down.
Mode  input  2  end-of-count mode: 00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
D  input  WIDTH  parallel load value.
Max  input  WIDTH  terminal value for up-count; count range is 0..Max.
Q  output  WIDTH  registered count.
CO  output  1  registered carry/borrow pulse.
TC  output  1  combinational terminal count for cascading.
Done  output  1  registered one-shot completion flag.

Behaviour:
- Reset: MR high asynchronously forces Q=RESET_VAL, CO=0, Done=0. This applies mid-count and mid-load, and overrides all other inputs.
- Priority at each rising CLK edge (MR low): Load low > EN high (hold) > CI low (hold) > Done high (hold) > count step.
- Load low: Q <= min(D, Max); CO <= 0; Done <= 0. Load ignores EN, CI and Mode.
- Hold (EN high, CI low, or Done high): Q and Done unchanged; CO <= 0. CO is a pulse and never stretches.
- Terminal condition:
  - Up: Q >= Max. The ">=" covers Max being lowered below Q at runtime.
  - Down: Q == 0.
- Count step, not at terminal: Q <= Q+1 (up) or Q-1 (down); CO <= 0.
- Count step at terminal: CO <= 1 for exactly one cycle, then by Mode:
  - Wrap: up goes to 0, down goes to Max.
  - Saturate: Q holds. CO pulses on every attempted step while at terminal.
  - One-shot: Q holds, Done <= 1, and all later steps are suppressed until Load or MR.
- TC = CI & ~EN & Load & ~Done & terminal. TC is combinational, so a higher stage's CI is true on the same edge the lower stage wraps.
- Max = 0: the range is {0}. Every enabled step is a terminal step, so CO pulses each step and Q stays 0.
- Direction change mid-count takes effect on the next step; no extra latency.
- Latency: Q, CO and Done update one cycle after the qualifying edge.
- Arithmetic is performed at WIDTH+1 bits internally; no overflow escapes to Q.

Decomposition:
- Package updn_counter_pkg holds:
  - Mode constants MODE_WRAP=2'b00, MODE_SAT=2'b01, MODE_ONESHOT=2'b10.
  - A typedef for the mode field.
- One sub-module, updn_next_calc, is natural. It is purely combinational: it takes Q, Max, Up_Dn and Mode and produces next_q, at_term and co_next. The top level holds the registers, priority logic and Done.

Test Plan:
1. Reset: WIDTH=4, MR pulsed high between clock edges while counting -> Q=0, CO=0, Done=0 immediately, before the next edge.
2. Wrap up: Mode=00, Max=9, Up_Dn=0, EN=0, CI=1, from Q=0 -> Q counts 0..9 then 0; CO=1 only in the cycle Q returns to 0; TC=1 while Q=9.
3. Wrap down: Mode=00, Max=9, Up_Dn=1, load D=2 -> Q=2,1,0,9,8; CO pulses once, coincident with Q=9.
4. Saturate and clamp: Mode=01, Max=5, load D=12 -> Q=5. Counting up -> Q stays 5 and CO=1 each enabled cycle. Set EN=1 -> CO=0 next cycle.
5. One-shot: Mode=10, Max=3, up from 0 -> Q=0,1,2,3; next edge Done=1 and CO pulses once; further edges keep Q=3; Load low with D=1 -> Q=1, Done=0.
6. Cascade: two instances, stage0 TC drives stage1 CI, both Max=15, Mode=00, counting up -> the 8-bit composite counts 0x00..0xFF then wraps. Stage1 CO pulses only at 0xFF->0x00. Lowering stage0 Max to 3 while stage0 Q=7 -> stage0 wraps to 0 on the next step.
